// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - 32-bit signed/unsigned restoring divider for the EX stage
// One quotient bit per cycle; result is {remainder, quotient}.
module ex_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stall_req_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state, state_n;
   logic [5:0]  cnt;
   logic [31:0] rem, quo, dvs;
   logic [63:0] result;
   logic        sgn_mode, neg_quo, neg_rem;

   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, diff;
   logic        accept;

   assign accept = start_i && !annul_i;
   assign abs_a  = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign abs_b  = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

   // Partial remainder is always below the divisor, so a failed trial fits back in 32 bits.
   assign shifted = {rem, quo[31]};
   assign diff    = shifted - {1'b0, dvs};

   always_comb begin
      state_n = state;
      case (state)
         FREE:    if (accept) state_n = (opdata2_i == 32'd0) ? BYZERO : ON;
         BYZERO:  state_n = annul_i ? FREE : END;
         ON: begin
            if (annul_i)             state_n = FREE;
            else if (cnt == 6'd32)   state_n = END;
         end
         END:     if (!start_i) state_n = FREE;
         default: state_n = FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FREE;
         cnt      <= 6'd0;
         rem      <= 32'd0;
         quo      <= 32'd0;
         dvs      <= 32'd0;
         result   <= 64'd0;
         sgn_mode <= 1'b0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            FREE: begin
               if (accept) begin
                  cnt      <= 6'd0;
                  rem      <= 32'd0;
                  quo      <= abs_a;
                  dvs      <= abs_b;
                  sgn_mode <= signed_i;
                  neg_quo  <= signed_i && (opdata1_i[31] ^ opdata2_i[31]);
                  neg_rem  <= signed_i && opdata1_i[31];
               end
            end
            BYZERO: result <= 64'd0;
            ON: begin
               if (!annul_i) begin
                  if (cnt != 6'd32) begin
                     if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                     end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                     end
                     cnt <= cnt + 6'd1;
                  end else begin
                     result[63:32] <= (sgn_mode && neg_rem) ? -rem : rem;
                     result[31:0]  <= (sgn_mode && neg_quo) ? -quo : quo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o     = (state == END);
   assign result_o    = ready_o ? result : 64'd0;
   assign stall_req_o = start_i && !ready_o && !annul_i;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - randomized self-checking bench for ex_div_unit
// Reference results come from plain 64-bit integer division.
module tb_ex_div_unit;

   logic        clk = 1'b0;
   logic        reset, start, sgn, annul;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready, stall;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start),
      .signed_i    (sgn),
      .opdata1_i   (op1),
      .opdata2_i   (op2),
      .annul_i     (annul),
      .result_o    (result),
      .ready_o     (ready),
      .stall_req_o (stall)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint la, lb, q, r;
      if (b == 32'd0) return 64'd0;
      la = s ? longint'($signed(a)) : longint'({32'd0, a});
      lb = s ? longint'($signed(b)) : longint'({32'd0, b});
      q = la / lb;
      r = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Called at a negedge; that cycle is the acceptance cycle T.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit pulse_end, input string tag);
      logic [63:0] exp;
      int          k;
      bit          stall_ok;
      exp   = ref_div(a, b, s);
      start = 1'b1;
      sgn   = s;
      op1   = a;
      op2   = b;
      #1;
      stall_ok = (stall === 1'b1);
      @(negedge clk);
      op1 = $urandom;
      op2 = $urandom;
      sgn = 1'($urandom);
      k   = 1;
      while (ready !== 1'b1 && k < 40) begin
         if (stall !== 1'b1) stall_ok = 1'b0;
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 64'(k), (b == 32'd0) ? 64'd2 : 64'd34);
      check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
      check({tag, " result"}, result, exp);
      check({tag, " stall_done"}, 64'(stall), 64'd0);
      if (pulse_end) begin
         annul = 1'b1;
         @(negedge clk);
         annul = 1'b0;
         check({tag, " end_annul_ready"}, 64'(ready), 64'd1);
         check({tag, " end_annul_result"}, result, exp);
      end
      start = 1'b0;
      @(negedge clk);
      check({tag, " free_ready"}, 64'(ready), 64'd0);
      check({tag, " free_result"}, result, 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      bit          quiet;

      reset = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      annul = 1'b0;
      op1   = 32'd0;
      op2   = 32'd0;
      repeat (3) @(negedge clk);
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      check("reset stall", 64'(stall), 64'd0);
      reset = 1'b0;

      run_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
      check("u100_7 model", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "s-7_2");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_min_m1");
      run_div(32'd123, 32'd0, 1'b0, 1'b0, "u_by0");
      run_div(32'h8000_0001, 32'd0, 1'b1, 1'b1, "s_by0");

      // annul at T+10; the next divide is accepted at T+11, which only works from FREE
      start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
      repeat (10) @(negedge clk);
      annul = 1'b1;
      #1 check("annul stall", 64'(stall), 64'd0);
      @(negedge clk);
      annul = 1'b0;
      check("annul ready", 64'(ready), 64'd0);
      run_div(32'd9, 32'd3, 1'b0, 1'b0, "u9_3");

      // reset in the middle of an iteration
      start = 1'b1; sgn = 1'b1; op1 = 32'h1234_5678; op2 = 32'd3;
      repeat (20) @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("midreset ready", 64'(ready), 64'd0);
      check("midreset result", result, 64'd0);
      check("midreset stall", 64'(stall), 64'd0);
      reset = 1'b0;
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "u_max_1");
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (ready !== 1'b0) quiet = 1'b0;
      end
      check("idle no_ready", 64'(quiet), 64'd1);

      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = -($urandom_range(1, 15));
            4:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_div(a, b, s, 1'(i % 5 == 0), $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
